// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage mult/div request bundle and HI/LO result/status bundle.
// The master side is the pipeline (EX issue, hazard unit, WB reads); the slave side is the unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             multordivE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, multordivE, signedE, srcaE, srcbE,
        input  busy, done, hi, lo
    );

    modport slave (
        input  startE, multordivE, signedE, srcaE, srcbE,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide owning the HI/LO registers, one bit per cycle.
// Build macro SIGNED_MD_EN adds two's-complement mult/div selected by signedE; without it all ops are unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int              CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE_COUNT  = CW'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = ~v + WIDTH'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
        logic [2*WIDTH-1:0] r;
        if (en) begin
            r = ~v + (2*WIDTH)'(1'b1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      count_r;
    // Upper half: partial product / running remainder. Lower half: multiplier / dividend->quotient.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opb_r;
    logic               is_div_r;
    logic               neg_main_r;
    logic               neg_rem_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               sign_a_s;
    logic               sign_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_res_s;
    logic [WIDTH-1:0]   lo_res_s;

`ifndef SIGNED_MD_EN
    logic unused_signed_s;
    assign unused_signed_s = bus.signedE;
`endif

    // Operand magnitudes, one iteration step of each datapath, and the sign-corrected final result.
    always_comb begin
`ifdef SIGNED_MD_EN
        sign_a_s = bus.signedE & bus.srcaE[WIDTH-1];
        sign_b_s = bus.signedE & bus.srcbE[WIDTH-1];
`else
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
`endif
        mag_a_s = neg_if(bus.srcaE, sign_a_s);
        mag_b_s = neg_if(bus.srcbE, sign_b_s);

        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end

        // Remainder is always below the divisor, so the W-bit difference is exact when it is kept.
        div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opb_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - opb_r;

        prod_s = neg2_if(acc_r, neg_main_r);
        if (is_div_r) begin
            hi_res_s = neg_if(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
            lo_res_s = neg_if(acc_r[WIDTH-1:0], neg_main_r);
        end else begin
            hi_res_s = prod_s[2*WIDTH-1:WIDTH];
            lo_res_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with the iterating accumulator, done pulse and HI/LO write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= {CW{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opb_r      <= ZERO_W;
            is_div_r   <= 1'b0;
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= ZERO_W;
            lo_r       <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.startE) begin
                        count_r  <= {CW{1'b0}};
                        opb_r    <= mag_b_s;
                        is_div_r <= bus.multordivE;
                        if (!bus.multordivE) begin
                            acc_r      <= {ZERO_W, mag_a_s};
                            neg_main_r <= sign_a_s ^ sign_b_s;
                            neg_rem_r  <= 1'b0;
                            state_r    <= MUL;
                        end else if (bus.srcbE != ZERO_W) begin
                            acc_r      <= {ZERO_W, mag_a_s};
                            neg_main_r <= sign_a_s ^ sign_b_s;
                            neg_rem_r  <= sign_a_s;
                            state_r    <= DIV;
                        end else begin
                            // Divide by zero: result is staged raw so DONE writes it unchanged.
                            acc_r      <= {bus.srcaE, ALL_ONES};
                            neg_main_r <= 1'b0;
                            neg_rem_r  <= 1'b0;
                            done_r     <= 1'b1;
                            state_r    <= DONE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    acc_r   <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    count_r <= count_r + ONE_COUNT;
                    if (count_r == LAST_COUNT) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DIV: begin
                    if (div_ge_s) begin
                        acc_r <= {div_diff_s, acc_r[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_r <= {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
                    end
                    count_r <= count_r + ONE_COUNT;
                    if (count_r == LAST_COUNT) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= DIV;
                    end
                end
                DONE: begin
                    hi_r    <= hi_res_s;
                    lo_r    <= lo_res_s;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = bus.startE | (state_r != IDLE);
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit against a timeline/arithmetic reference model.
// The model tracks op latency by cycle number and computes results with plain 64-bit arithmetic.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef SIGNED_MD_EN
    localparam bit SIGNED_CFG = 1'b1;
`else
    localparam bit SIGNED_CFG = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic void ref_op(input logic div, input logic sgn, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh, output logic [31:0] rl);
        logic [63:0] p;
        longint      sa, sb, q, r;
        bit          use_signed;
        use_signed = sgn & SIGNED_CFG;
        if (div && b == 32'd0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else if (use_signed) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (div) begin
                q  = sa / sb;
                r  = sa % sb;
                rh = r[31:0];
                rl = q[31:0];
            end else begin
                p  = 64'(sa * sb);
                rh = p[63:32];
                rl = p[31:0];
            end
        end else if (div) begin
            rh = a % b;
            rl = a / b;
        end else begin
            p  = {32'd0, a} * {32'd0, b};
            rh = p[63:32];
            rl = p[31:0];
        end
    endfunction

    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_done_cyc = 0;
    int          m_upd_cyc  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi, p_lo;

    // Model and per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            chk("rst_busy", bus.busy, bus.startE);
            chk("rst_done", bus.done, 64'd0);
            chk("rst_hi", bus.hi, 64'd0);
            chk("rst_lo", bus.lo, 64'd0);
        end else begin
            if (m_active && cyc == m_upd_cyc) begin
                m_hi     = p_hi;
                m_lo     = p_lo;
                m_active = 1'b0;
            end
            chk("busy", bus.busy, bus.startE | m_active);
            chk("done", bus.done, m_active && cyc == m_done_cyc);
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
            if (bus.startE && !m_active) begin
                ref_op(bus.multordivE, bus.signedE, bus.srcaE, bus.srcbE, p_hi, p_lo);
                m_active   = 1'b1;
                m_done_cyc = cyc + ((bus.multordivE && bus.srcbE == 32'd0) ? 1 : W + 1);
                m_upd_cyc  = m_done_cyc + 1;
            end
        end
    end

    task automatic start_op(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.startE     = 1'b1;
        bus.multordivE = div;
        bus.signedE    = sgn;
        bus.srcaE      = a;
        bus.srcbE      = b;
        @(posedge clk); #1;
        bus.startE     = 1'b0;
    endtask

    // Returns the cycle offset (relative to the start cycle) at which done is seen.
    task automatic time_done(input int k0, output int k);
        k = k0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) return;
            k++;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: no done pulse within 100 cycles");
        k = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        checks++;
        failures++;
        $display("FAIL idle_timeout: busy still high after 100 cycles");
    endtask

    initial begin
        int k;
        bus.startE     = 1'b0;
        bus.multordivE = 1'b0;
        bus.signedE    = 1'b0;
        bus.srcaE      = 32'd0;
        bus.srcbE      = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 7*6: done at T+33, result from T+34
        start_op(1'b0, 1'b0, 32'd7, 32'd6);
        time_done(1, k);
        chk("mul76_done_offset", k, 64'd33);
        @(negedge clk);
        chk("mul76_hi", bus.hi, 64'd0);
        chk("mul76_lo", bus.lo, 64'd42);
        chk("mul76_idle", bus.busy, 64'd0);

        // Max unsigned product
        start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        chk("mulmax_hi", bus.hi, 64'hFFFF_FFFE);
        chk("mulmax_lo", bus.lo, 64'h0000_0001);

        // 100/7 with a stray start at T+5 that must be ignored
        @(posedge clk); #1;
        bus.startE = 1'b1; bus.multordivE = 1'b1; bus.signedE = 1'b0;
        bus.srcaE = 32'd100; bus.srcbE = 32'd7;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        repeat (4) @(posedge clk); #1;
        bus.startE = 1'b1; bus.multordivE = 1'b0; bus.srcaE = 32'd9; bus.srcbE = 32'd9;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        time_done(6, k);
        chk("div100_done_offset", k, 64'd33);
        @(negedge clk);
        chk("div100_lo", bus.lo, 64'd14);
        chk("div100_hi", bus.hi, 64'd2);

        // 5/0: done at T+1, result at T+2
        start_op(1'b1, 1'b0, 32'd5, 32'd0);
        time_done(1, k);
        chk("div0_done_offset", k, 64'd1);
        @(negedge clk);
        chk("div0_hi", bus.hi, 64'd5);
        chk("div0_lo", bus.lo, 64'hFFFF_FFFF);
        chk("div0_idle", bus.busy, 64'd0);

        // 3*3 aborted by reset at T+10
        start_op(1'b0, 1'b0, 32'd3, 32'd3);
        repeat (9) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 64'd0);
        chk("abort_done", bus.done, 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        start_op(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle();
        chk("mul_after_reset", {bus.hi, bus.lo}, 64'h0B00_EA4E_242D_2080);

        // Back-to-back: second op issued in the first idle cycle
        start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
        time_done(1, k);
        start_op(1'b1, 1'b0, 32'd3, 32'd10);
        chk("divmax_lo", bus.lo, 64'hFFFF_FFFF);
        chk("divmax_hi", bus.hi, 64'd0);
        wait_idle();
        chk("div3_10", {bus.hi, bus.lo}, {32'd3, 32'd0});

        // -7/2 signed request
        start_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        chk("sdiv_lo", bus.lo, SIGNED_CFG ? 64'hFFFF_FFFD : 64'h7FFF_FFFC);
        chk("sdiv_hi", bus.hi, SIGNED_CFG ? 64'hFFFF_FFFF : 64'h0000_0001);

        // -3*5 signed request
        start_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        chk("smul", {bus.hi, bus.lo}, SIGNED_CFG ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);

        // 0*x and signed div-by-zero
        start_op(1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF);
        wait_idle();
        chk("mul_zero", {bus.hi, bus.lo}, 64'd0);
        start_op(1'b1, 1'b1, 32'h8000_0001, 32'd0);
        wait_idle();
        chk("sdiv0", {bus.hi, bus.lo}, {32'h8000_0001, 32'hFFFF_FFFF});

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
